// File: rtl/serial_adder_8bit_if.sv
// serial_adder_8bit_if: start/done handshake and operand/result
// bundle for the bit-serial adder.
interface serial_adder_8bit_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// serial_adder_8bit: one full adder plus carry flop, one sum bit
// per clock, 8 clocks from accept to done.
module serial_adder_8bit (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_8bit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ra_q, ra_d;
  logic [7:0] rb_q, rb_d;
  logic [7:0] ps_q, ps_d;
  logic [7:0] sum_q, sum_d;
  logic       carry_q, carry_d;
  logic       cout_q, cout_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load;
  logic       s;
  logic       c;

  // Full adder on the operand LSBs and the running carry.
  always_comb begin
    s = ra_q[0] ^ rb_q[0] ^ carry_q;
    c = (ra_q[0] & rb_q[0])
      | (ra_q[0] & carry_q)
      | (rb_q[0] & carry_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath next values; load picks word vs shift.
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          carry_d = bus.cin;
          ps_d    = 8'h00;
          cnt_d   = 3'd0;
          state_d = ADD;
        end
      end
      ADD: begin
        ps_d    = {s, ps_q[7:1]};
        carry_d = c;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          sum_d   = {s, ps_q[7:1]};
          cout_d  = c;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ra_d = load ? bus.a : {1'b0, ra_q[7:1]};
    rb_d = load ? bus.b : {1'b0, rb_q[7:1]};
  end

  // Datapath registers; operands only move while loading or adding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q    <= 8'h00;
      rb_q    <= 8'h00;
      ps_q    <= 8'h00;
      carry_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else if (load || state_q == ADD) begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers, written only on the final ADD edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= 8'h00;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_8bit.sv
// tb_serial_adder_8bit: directed and random operations checked
// against a timing/arithmetic model of the serial adder.
module tb_serial_adder_8bit;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  int   ndone;
  bit   chk_en;

  serial_adder_8bit_if bus();

  serial_adder_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an op accepted at edge number acc is busy after edges
  // acc..acc+7, done after acc+8, idle again after acc+9.
  int         e;
  int         acc;
  bit         act;
  logic [8:0] pend;
  logic [8:0] mres;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act  = 1'b0;
      mres = 9'h000;
    end else begin
      e++;
      if (act && (e - acc) == 8) mres = pend;
      if (bus.start && (!act || (e - acc) >= 10)) begin
        act  = 1'b1;
        acc  = e;
        pend = {1'b0, bus.a} + {1'b0, bus.b} + {8'h00, bus.cin};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", bus.busy, act && (e - acc) <= 7);
      chk("done", bus.done, act && (e - acc) == 8);
      chk("result", {bus.cout, bus.sum}, mres);
      chk("busy_done_excl", bus.busy & bus.done, 1'b0);
      if (bus.done) ndone++;
    end
  end

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [8:0] lit,
                       input bit poke);
    bit got;
    @(posedge clk); #1;
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (poke) begin
      bus.a = ~ta; bus.b = 8'h5A; bus.cin = ~tc;
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL done_timeout: no done for a=%h b=%h", ta, tb_);
    end else begin
      chk("op_literal", {bus.cout, bus.sum}, lit);
    end
    if (poke) begin
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
  endtask

  initial begin
    int d0;
    logic [7:0] ra, rb;
    logic rc;
    nvec = 0; nmis = 0; ndone = 0; chk_en = 1'b0;
    e = 0; acc = 0; act = 1'b0; pend = '0; mres = '0;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_res", {bus.cout, bus.sum}, 9'h000);
    @(posedge clk); #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_res", {bus.cout, bus.sum}, 9'h000);

    do_op(8'b10010101, 8'b10111111, 1'b0, 9'h154, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0);
    @(posedge clk); #1;
    bus.a = 8'h3C; bus.b = 8'h0A; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("hold_prev", {bus.cout, bus.sum}, 9'h100);
    repeat (5) @(posedge clk); #1;
    chk("second_res", {bus.cout, bus.sum}, 9'h046);

    do_op(8'h12, 8'h34, 1'b1, 9'h047, 1'b1);

    repeat (2) @(posedge clk); #1;
    d0 = ndone;
    bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b1; bus.start = 1'b1;
    repeat (25) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    chk("hold_start_dones", ndone - d0, 3);
    #1;
    chk("hold_start_res", {bus.cout, bus.sum}, 9'h101);

    @(posedge clk); #1;
    bus.a = 8'h55; bus.b = 8'hAA; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_res", {bus.cout, bus.sum}, 9'h000);
    d0 = ndone;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", ndone - d0, 0);
    do_op(8'h01, 8'h01, 1'b0, 9'h002, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      do_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc},
            (i % 7) == 0);
    end

    repeat (12) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
